// File: rtl/leaf_stream_rx.sv
// BFT leaf stream receiver: filters packets for this leaf/port into a FIFO, streams payloads to the
// user and returns free-space credit packets. Optional sequence checking is enabled with SEQ_CHECK_EN.
module leaf_stream_rx #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned MY_LEAF               = 1,
  parameter int unsigned MY_PORT               = 2,
  parameter int unsigned CREDIT_LEAF           = 0,
  parameter int unsigned CREDIT_PORT           = 0,
  parameter int unsigned FIFO_ADDR_BITS        = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2rx,
  output logic [PACKET_BITS-1:0]  dout_rx2bft,
  input  logic                    resend,
  output logic [PAYLOAD_BITS-1:0] dout_rx2user,
  output logic                    vld_rx2user,
  input  logic                    ack_user2rx,
  output logic                    overflow,
  output logic                    seq_err
);

  localparam int unsigned Depth   = 2 ** FIFO_ADDR_BITS;
  localparam int unsigned CntBits = FIFO_ADDR_BITS + 1;
  localparam logic [FIFO_ADDR_BITS-1:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

  logic [PAYLOAD_BITS-1:0]   mem [Depth];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntBits-1:0]        count_q, count_d;
  logic                      vld_q, overflow_q;
  logic                      match, full, wr_en, rd_en;

  state_e                    state_q, state_d;
  logic [CntBits-1:0]        consumed_q, consumed_d, consumed_sum, free_slots;
  logic [PACKET_BITS-1:0]    credit_q, credit_d, dout_q, dout_d, credit_pkt;

  assign match = din_leaf_bft2rx[48]
               && (din_leaf_bft2rx[47:44] == 4'(MY_LEAF))
               && (din_leaf_bft2rx[43:40] == 4'(MY_PORT));
  // Full is judged on the registered count, so a same-cycle read cannot rescue a packet.
  assign full    = (count_q == CntBits'(Depth));
  assign wr_en   = match && !full;
  assign rd_en   = vld_q && ack_user2rx;
  assign count_d = count_q + CntBits'(wr_en) - CntBits'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din_leaf_bft2rx[PAYLOAD_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vld_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
      vld_q   <= (count_d != '0);
      if (match && full) overflow_q <= 1'b1;
    end
  end

  assign vld_rx2user  = vld_q;
  assign dout_rx2user = vld_q ? mem[rd_ptr_q] : '0;
  assign overflow     = overflow_q;

  // Credit reports the space left after this cycle's FIFO update.
  assign free_slots   = CntBits'(Depth) - count_d;
  assign credit_pkt   = {1'b1, 4'(CREDIT_LEAF), 4'(CREDIT_PORT), 7'd0, 1'b0,
                         PAYLOAD_BITS'(free_slots)};
  assign consumed_sum = consumed_q + CntBits'(rd_en);

  always_comb begin
    state_d    = state_q;
    consumed_d = consumed_sum;
    credit_d   = credit_q;
    dout_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (consumed_sum >= CntBits'(FREESPACE_UPDATE_SIZE)) begin
          consumed_d = consumed_sum - CntBits'(FREESPACE_UPDATE_SIZE);
          credit_d   = credit_pkt;
          dout_d     = credit_pkt;
          state_d    = StSend;
        end else if (resend) begin
          dout_d = credit_q;
        end
      end
      StSend:  state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      consumed_q <= '0;
      credit_q   <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      consumed_q <= consumed_d;
      credit_q   <= credit_d;
      dout_q     <= dout_d;
    end
  end

  assign dout_rx2bft = dout_q;

`ifdef SEQ_CHECK_EN
  logic [6:0] seq_exp_q;
  logic       seq_err_q;
  logic       unused_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_exp_q <= '0;
      seq_err_q <= 1'b0;
    end else if (wr_en) begin
      // Resync to the received sequence so one gap flags once, not on every later packet.
      seq_exp_q <= din_leaf_bft2rx[39:33] + 7'd1;
      if (din_leaf_bft2rx[39:33] != seq_exp_q) seq_err_q <= 1'b1;
    end
  end

  assign seq_err     = seq_err_q;
  assign unused_bits = din_leaf_bft2rx[32];
`else
  logic unused_bits;
  assign seq_err     = 1'b0;
  assign unused_bits = ^din_leaf_bft2rx[39:32];
`endif

endmodule

// File: tb/tb_leaf_stream_rx.sv
// Self-checking bench for leaf_stream_rx: scoreboard model checked every cycle plus a vector table
// and directed sequences for latency, hold, overflow, credit/resend and mid-operation reset.
module tb_leaf_stream_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [48:0] din = '0;
  logic [48:0] dout_bft;
  logic        resend = 1'b0;
  logic [31:0] dout_user;
  logic        vld;
  logic        ack = 1'b0;
  logic        overflow;
  logic        seq_err;

  int n_cmp = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  leaf_stream_rx dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .din_leaf_bft2rx (din),
    .dout_rx2bft     (dout_bft),
    .resend          (resend),
    .dout_rx2user    (dout_user),
    .vld_rx2user     (vld),
    .ack_user2rx     (ack),
    .overflow        (overflow),
    .seq_err         (seq_err)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model, updated on the same edges as the DUT
  logic [31:0] sb[$];
  int          m_count;
  int          m_consumed;
  int          credits_seen;
  logic        m_ovf, m_seqerr;
  logic [48:0] m_credit_now, m_last_credit;
  bit          hit_d1, hit_d2;
`ifdef SEQ_CHECK_EN
  logic [6:0]  m_seq_exp;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      m_count = 0; m_consumed = 0; m_ovf = 1'b0; m_seqerr = 1'b0;
      m_credit_now = '0; m_last_credit = '0; hit_d1 = 1'b0; hit_d2 = 1'b0;
`ifdef SEQ_CHECK_EN
      m_seq_exp = '0;
`endif
    end else begin
      bit match, rd, hit;
      match = din[48] && (din[47:44] == 4'd1) && (din[43:40] == 4'd2);
      rd    = (m_count != 0) && ack;
      hit   = 1'b0;
      if (match) begin
        if (m_count < 128) begin
          sb.push_back(din[31:0]);
          m_count++;
`ifdef SEQ_CHECK_EN
          if (din[39:33] != m_seq_exp) m_seqerr = 1'b1;
          m_seq_exp = din[39:33] + 7'd1;
`endif
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (rd) begin
        m_count--;
        m_consumed++;
        if (m_consumed == 64) begin
          m_consumed = 0;
          hit = 1'b1;
        end
      end
      m_credit_now = '0;
      if (hit) begin
        m_last_credit = {1'b1, 4'd0, 4'd0, 7'd0, 1'b0, 32'(128 - m_count)};
        m_credit_now  = m_last_credit;
      end else if (resend && !hit_d1 && !hit_d2) begin
        m_credit_now = m_last_credit;
      end
      hit_d2 = hit_d1;
      hit_d1 = hit;
    end
  end

  always @(negedge clk) begin
    if (reset_n && checking) begin
      check("vld", {63'd0, vld}, {63'd0, m_count != 0});
      if (m_count != 0) begin
        check("head", {32'd0, dout_user}, {32'd0, sb[0]});
        if (ack) void'(sb.pop_front());
      end
      check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      check("seq_err", {63'd0, seq_err}, {63'd0, m_seqerr});
      check("credit", {15'd0, dout_bft}, {15'd0, m_credit_now});
      if (dout_bft != '0) credits_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [3:0] leaf, input logic [3:0] port,
                      input logic [6:0] seq, input logic [31:0] pl);
    din = {v, leaf, port, seq, 1'b0, pl};
    step(1);
    din = '0;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  leaf;
    logic [3:0]  port;
    logic [31:0] pl;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int got;
    vecs[0] = '{1'b1, 4'd2, 4'd2, 32'h100, 1'b0};  // leaf off by one
    vecs[1] = '{1'b1, 4'd1, 4'd3, 32'h101, 1'b0};  // wrong port
    vecs[2] = '{1'b0, 4'd1, 4'd2, 32'h102, 1'b0};  // valid bit clear
    vecs[3] = '{1'b1, 4'd0, 4'd2, 32'h103, 1'b0};
    vecs[4] = '{1'b1, 4'd1, 4'd2, 32'h104, 1'b1};  // the only match
    vecs[5] = '{1'b1, 4'd1, 4'd0, 32'h105, 1'b1};

    // Reset state
    step(3);
    check("rst vld", {63'd0, vld}, 64'd0);
    check("rst dout_user", {32'd0, dout_user}, 64'd0);
    check("rst dout_bft", {15'd0, dout_bft}, 64'd0);
    check("rst overflow", {63'd0, overflow}, 64'd0);
    check("rst seq_err", {63'd0, seq_err}, 64'd0);
    reset_n = 1'b1;
    checking = 1'b1;
    step(2);

    // In-order delivery with 1-cycle latency; seq gap at 3 flags only when checking is built in
    ack = 1'b1;
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'hA);
    check("write-to-vld latency", {63'd0, vld}, 64'd1);
    send(1'b1, 4'd1, 4'd2, 7'd1, 32'hB);
    send(1'b1, 4'd1, 4'd2, 7'd3, 32'hC);
    send(1'b1, 4'd1, 4'd2, 7'd4, 32'hD);
    step(4);
`ifdef SEQ_CHECK_EN
    check("seq_err sticky", {63'd0, seq_err}, 64'd1);
`else
    check("seq_err tied", {63'd0, seq_err}, 64'd0);
`endif
    check("drained after ABCD", 64'(sb.size()), 64'd0);

    // Address filtering
    ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].v, vecs[i].leaf, vecs[i].port, 7'd0, vecs[i].pl);
      check($sformatf("vec%0d vld", i), {63'd0, vld}, {63'd0, vecs[i].exp_vld});
    end
    ack = 1'b1;
    step(3);
    ack = 1'b0;

    // Head holds while ack is low, then exactly one word moves
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'h1111);
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'h2222);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold head", {32'd0, dout_user}, 64'h1111);
    end
    step(0);
    @(posedge clk); #1;
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("one word consumed", {32'd0, dout_user}, 64'h2222);
    check("still valid", {63'd0, vld}, 64'd1);
    ack = 1'b1;
    step(2);
    ack = 1'b0;

    // Overflow: 129 packets into an empty FIFO, then drain
    for (int i = 0; i < 129; i++) send(1'b1, 4'd1, 4'd2, 7'd0, 32'h5000 + 32'(i));
    check("overflow set", {63'd0, overflow}, 64'd1);
    check("stored words", 64'(sb.size()), 64'd128);
    ack = 1'b1;
    got = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (vld && ack) got++;
    end
    step(0);
    @(posedge clk); #1;
    ack = 1'b0;
    check("drained words", 64'(got), 64'd128);
    check("credits during run", 64'(credits_seen), 64'd2);

    // Resend well after the last credit: 7 words consumed earlier, so the 121st drain word
    // crossed the threshold leaving 7 words, i.e. 121 free slots.
    step(10);
    resend = 1'b1;
    step(1);
    resend = 1'b0;
    check("resend packet", {15'd0, dout_bft}, {15'd0, 1'b1, 4'd0, 4'd0, 7'd0, 1'b0, 32'd121});
    step(1);
    check("resend one cycle", {15'd0, dout_bft}, 64'd0);
    check("credits after resend", 64'(credits_seen), 64'd3);

    // Asynchronous reset with data in flight
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'h77);
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'h78);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-reset vld", {63'd0, vld}, 64'd0);
    check("mid-reset overflow", {63'd0, overflow}, 64'd0);
    check("mid-reset dout_user", {32'd0, dout_user}, 64'd0);
    step(1);
    reset_n = 1'b1;
    step(1);
    ack = 1'b1;
    send(1'b1, 4'd1, 4'd2, 7'd0, 32'h99);
    check("post-reset vld", {63'd0, vld}, 64'd1);
    check("post-reset head", {32'd0, dout_user}, 64'h99);
    step(3);
    check("final empty", 64'(sb.size()), 64'd0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
